seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 181 ++++++++++++++++++
 tb/tb_seq_divider.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider with valid/ready handshakes on both sides.
// One quotient bit per cycle on operand magnitudes; sign fixup and special cases applied on the last step.
module seq_divider #(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [WIDTH-1:0] s_axis_dividend,
    input  logic [WIDTH-1:0] s_axis_divisor,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [WIDTH-1:0] m_axis_quotient,
    output logic [WIDTH-1:0] m_axis_remainder,
    output logic             m_axis_divzero,
    output logic             m_axis_overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;       // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH:0]   dvs_q, dvs_d;       // divisor magnitude
    logic             sd_q, sd_d;         // dividend sign
    logic             sv_q, sv_d;         // divisor sign
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] qout_q, qout_d;
    logic [WIDTH-1:0] rout_q, rout_d;

    // Operand signs and WIDTH+1-bit magnitudes so that |MIN| is representable.
    logic             in_sd;
    logic             in_sv;
    logic [WIDTH:0]   ext_dd;
    logic [WIDTH:0]   ext_dv;
    logic [WIDTH:0]   mag_dd;
    logic [WIDTH:0]   mag_dv;
    logic             in_dz;
    logic             in_ov;

    always_comb begin
        in_sd  = (SIGNED != 0) && s_axis_dividend[WIDTH-1];
        in_sv  = (SIGNED != 0) && s_axis_divisor[WIDTH-1];
        ext_dd = {in_sd, s_axis_dividend};
        ext_dv = {in_sv, s_axis_divisor};
        mag_dd = in_sd ? (~ext_dd + {{WIDTH{1'b0}}, 1'b1}) : ext_dd;
        mag_dv = in_sv ? (~ext_dv + {{WIDTH{1'b0}}, 1'b1}) : ext_dv;
        in_dz  = (s_axis_divisor == '0);
        in_ov  = (SIGNED != 0) && (s_axis_dividend == MIN_VAL) && (s_axis_divisor == '1);
    end

    // One restoring step.
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    always_comb begin
        trial    = {rem_q, quo_q[WIDTH-1]};
        ge       = (trial >= dvs_q);
        rem_step = ge ? (trial[WIDTH-1:0] - dvs_q[WIDTH-1:0]) : trial[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], ge};
    end

    // Sign fixup of the final step; a zero divisor leaves |dividend| in the remainder,
    // so the dividend-sign fixup reproduces the dividend itself.
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    always_comb begin
        q_fix = (sd_q ^ sv_q) ? (~quo_step + WIDTH'(1)) : quo_step;
        r_fix = sd_q ? (~rem_step + WIDTH'(1)) : rem_step;
        q_fin = q_fix;
        r_fin = r_fix;
        if (ov_q) begin
            q_fin = MIN_VAL;
            r_fin = '0;
        end else if (dz_q) begin
            if (SIGNED != 0) begin
                q_fin = sd_q ? MIN_VAL : MAX_VAL;
            end else begin
                q_fin = '1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sd_d    = sd_q;
        sv_d    = sv_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        qout_d  = qout_q;
        rout_d  = rout_q;
        case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    sd_d    = in_sd;
                    sv_d    = in_sv;
                    dz_d    = in_dz;
                    ov_d    = in_ov;
                    rem_d   = {{(WIDTH-1){1'b0}}, mag_dd[WIDTH]};
                    quo_d   = mag_dd[WIDTH-1:0];
                    dvs_d   = mag_dv;
                    cnt_d   = '0;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    qout_d  = q_fin;
                    rout_d  = r_fin;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (m_axis_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            sd_q    <= 1'b0;
            sv_q    <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
            qout_q  <= '0;
            rout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            sd_q    <= sd_d;
            sv_q    <= sv_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
        end
    end

    assign s_axis_tready    = (state_q == IDLE);
    assign m_axis_tvalid    = (state_q == DONE);
    assign m_axis_quotient  = qout_q;
    assign m_axis_remainder = rout_q;
    assign m_axis_divzero   = dz_q;
    assign m_axis_overflow  = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32, signed): hand-computed results, latency,
// backpressure hold and reset abort.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [W-1:0] s_axis_dividend;
    logic [W-1:0] s_axis_divisor;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [W-1:0] m_axis_quotient;
    logic [W-1:0] m_axis_remainder;
    logic         m_axis_divzero;
    logic         m_axis_overflow;

    int n_vec = 0;
    int n_bad = 0;

    seq_divider #(.WIDTH(W), .SIGNED(1)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_dividend  (s_axis_dividend),
        .s_axis_divisor   (s_axis_divisor),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_quotient  (m_axis_quotient),
        .m_axis_remainder (m_axis_remainder),
        .m_axis_divzero   (m_axis_divzero),
        .m_axis_overflow  (m_axis_overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Latency counts the accepting cycle as cycle 0; tvalid must first be seen in cycle 33.
    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                           input logic exp_dz, input logic exp_ov);
        int cyc;
        cyc = 0;
        while (!s_axis_tready && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "/ready"}, 64'(s_axis_tready), 64'(1));
        s_axis_tvalid   = 1'b1;
        s_axis_dividend = a;
        s_axis_divisor  = b;
        tick();
        s_axis_tvalid   = 1'b0;
        s_axis_dividend = 32'hDEAD_BEEF;
        s_axis_divisor  = 32'h0000_0001;
        cyc = 1;
        while (!m_axis_tvalid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "/latency"}, 64'(cyc), 64'(33));
        chk({tag, "/quot"}, 64'(m_axis_quotient), 64'(exp_q));
        chk({tag, "/rem"}, 64'(m_axis_remainder), 64'(exp_r));
        chk({tag, "/divzero"}, 64'(m_axis_divzero), 64'(exp_dz));
        chk({tag, "/overflow"}, 64'(m_axis_overflow), 64'(exp_ov));
        $display("div %s: 0x%h / 0x%h -> q=0x%h r=0x%h dz=%b ov=%b latency=%0d",
                 tag, a, b, m_axis_quotient, m_axis_remainder, m_axis_divzero, m_axis_overflow, cyc);
        tick();
        chk({tag, "/tready_next"}, 64'(s_axis_tready), 64'(1));
        chk({tag, "/tvalid_drop"}, 64'(m_axis_tvalid), 64'(0));
    endtask

    task automatic expect_silence(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            if (m_axis_tvalid) seen = 1;
            tick();
        end
        chk(tag, 64'(seen), 64'(0));
    endtask

    initial begin
        int cyc;
        rst_in          = 1'b1;
        s_axis_tvalid   = 1'b0;
        s_axis_dividend = '0;
        s_axis_divisor  = '0;
        m_axis_tready   = 1'b1;
        repeat (3) tick();
        chk("reset/tready", 64'(s_axis_tready), 64'(1));
        chk("reset/tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("reset/quot", 64'(m_axis_quotient), 64'(0));
        chk("reset/rem", 64'(m_axis_remainder), 64'(0));
        chk("reset/flags", 64'({m_axis_divzero, m_axis_overflow}), 64'(0));
        $display("reset released");
        rst_in = 1'b0;
        tick();

        run_div("9/3",         32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 1'b0);
        run_div("65535/9",     32'd65535,      32'd9,          32'd7281,       32'd6,          1'b0, 1'b0);
        run_div("100/5",       32'd100,        32'd5,          32'd20,         32'd0,          1'b0, 1'b0);
        run_div("-7/2",        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0);
        run_div("7/-2",        32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0);
        run_div("-100/-7",     32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 1'b0);
        run_div("5/7",         32'd5,          32'd7,          32'd0,          32'd5,          1'b0, 1'b0);
        run_div("7/0",         32'd7,          32'd0,          32'h7FFF_FFFF,  32'd7,          1'b1, 1'b0);
        run_div("-7/0",        32'hFFFF_FFF9,  32'd0,          32'h8000_0000,  32'hFFFF_FFF9,  1'b1, 1'b0);
        run_div("0/0",         32'd0,          32'd0,          32'h7FFF_FFFF,  32'd0,          1'b1, 1'b0);
        run_div("MIN/-1",      32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 1'b1);
        run_div("MIN/1",       32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 1'b0);
        run_div("MIN/2",       32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0, 1'b0);

        // Backpressure: result held for 10 cycles while a second pair is offered.
        m_axis_tready   = 1'b0;
        s_axis_tvalid   = 1'b1;
        s_axis_dividend = 32'd100;
        s_axis_divisor  = 32'd5;
        tick();
        s_axis_dividend = 32'd3;
        s_axis_divisor  = 32'd1;
        cyc = 1;
        while (!m_axis_tvalid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("stall/latency", 64'(cyc), 64'(33));
        for (int i = 0; i < 10; i++) begin
            chk("stall/tvalid", 64'(m_axis_tvalid), 64'(1));
            chk("stall/tready", 64'(s_axis_tready), 64'(0));
            chk("stall/quot", 64'(m_axis_quotient), 64'(20));
            chk("stall/rem", 64'(m_axis_remainder), 64'(0));
            tick();
        end
        $display("stall: held q=0x%h r=0x%h for 10 cycles", m_axis_quotient, m_axis_remainder);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        tick();
        chk("stall/tready_after", 64'(s_axis_tready), 64'(1));
        expect_silence("stall/second_pair_ignored", 40);

        // Reset during DIVIDE aborts the operation.
        s_axis_tvalid   = 1'b1;
        s_axis_dividend = 32'd9;
        s_axis_divisor  = 32'd3;
        tick();
        s_axis_tvalid = 1'b0;
        repeat (9) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("abort/tready", 64'(s_axis_tready), 64'(1));
        chk("abort/tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("abort/quot", 64'(m_axis_quotient), 64'(0));
        chk("abort/rem", 64'(m_axis_remainder), 64'(0));
        $display("abort: reset pulsed in DIVIDE cycle 10");
        expect_silence("abort/no_result", 40);
        run_div("post_abort_100/5", 32'd100, 32'd5, 32'd20, 32'd0, 1'b0, 1'b0);

        // Reset wins over a simultaneous valid operand pair.
        rst_in          = 1'b1;
        s_axis_tvalid   = 1'b1;
        s_axis_dividend = 32'd9;
        s_axis_divisor  = 32'd3;
        tick();
        rst_in        = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("prio/tready", 64'(s_axis_tready), 64'(1));
        $display("priority: reset with s_axis_tvalid");
        expect_silence("prio/no_result", 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
